// File: rtl/ram2p_pkg.sv
// ram2p_pkg: shared types and defaults for the ram2p port-A arbiter
package ram2p_pkg;
  localparam int AWID_DEF = 8;
  localparam int DWID_DEF = 16;
  localparam int RID_W = 1;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
  typedef struct packed {
    logic             vld;
    logic [RID_W-1:0] id;
  } rtag_t;
endpackage

// File: rtl/ram2p_arb_tagq.sv
// ram2p_arb_tagq: fixed-depth delay line carrying read-return tags
module ram2p_arb_tagq #(
  parameter int DEPTH = 2,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [DEPTH];
  // shift one stage per cycle; reset drops every in-flight tag
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/ram2p_arb.sv
// ram2p_arb: round-robin, burst-limited arbiter sharing ram2p port A between two requesters
module ram2p_arb
  import ram2p_pkg::*;
#(
  parameter int AWID = AWID_DEF,
  parameter int DWID = DWID_DEF,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vld0,
  input  logic            i_vld1,
  input  logic            i_we0,
  input  logic            i_we1,
  input  logic [AWID-1:0] i_addr0,
  input  logic [AWID-1:0] i_addr1,
  input  logic [DWID-1:0] i_dat0,
  input  logic [DWID-1:0] i_dat1,
  output logic            o_rdy0,
  output logic            o_rdy1,
  output logic            o_rvld0,
  output logic            o_rvld1,
  output logic [DWID-1:0] o_rdat0,
  output logic [DWID-1:0] o_rdat1,
  output logic            o_ram_we,
  output logic [AWID-1:0] o_ram_addr,
  output logic [DWID-1:0] o_ram_dat,
  input  logic [DWID-1:0] i_ram_dat
);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic full, win, acc, sel_we;
  logic [AWID-1:0] sel_addr, ram_addr_q;
  logic [DWID-1:0] sel_dat, ram_dat_q, rdat0_q, rdat1_q;
  logic ram_we_q, rvld0_q, rvld1_q;
  rtag_t tag_in, tag_out;

  assign full = cnt_q >= CW'(MAX_BURST);
  assign sel_we = win ? i_we1 : i_we0;
  assign sel_addr = win ? i_addr1 : i_addr0;
  assign sel_dat = win ? i_dat1 : i_dat0;
  assign tag_in = '{vld: acc && !sel_we, id: win};

  // grant decision (win=1 means requester 1) and FSM/burst/pointer next state
  always_comb begin
    win = state_q == OWN0 ? (!i_vld0 || (full && i_vld1)) :
          state_q == OWN1 ? (i_vld1 && !(full && i_vld0)) :
          (i_vld0 && i_vld1) ? !last_q : i_vld1;
    o_rdy0 = !rst && i_vld0 && !win;
    o_rdy1 = !rst && i_vld1 && win;
    acc = o_rdy0 || o_rdy1;
    state_d = !acc ? IDLE : win ? OWN1 : OWN0;
    cnt_d = !acc ? '0 :
            state_q == (win ? OWN1 : OWN0) ? (full ? cnt_q : cnt_q + 1'b1) : CW'(1);
    last_d = acc ? win : last_q;
  end

  // FSM, burst counter, RAM command register and read-return steering
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_dat_q <= '0;
      rvld0_q <= 1'b0;
      rvld1_q <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      ram_we_q <= acc && sel_we;
      if (acc) ram_addr_q <= sel_addr;
      if (acc) ram_dat_q <= sel_dat;
      rvld0_q <= tag_out.vld && !tag_out.id[0];
      rvld1_q <= tag_out.vld && tag_out.id[0];
      if (tag_out.vld && !tag_out.id[0]) rdat0_q <= i_ram_dat;
      if (tag_out.vld && tag_out.id[0]) rdat1_q <= i_ram_dat;
    end
  end

  ram2p_arb_tagq #(.DEPTH(RD_LAT + 1), .W($bits(rtag_t))) u_tagq (
    .clk(clk),
    .rst(rst),
    .d_i(tag_in),
    .q_o(tag_out)
  );

  assign o_ram_we = ram_we_q && !rst;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_dat = ram_dat_q;
  assign o_rvld0 = rvld0_q;
  assign o_rvld1 = rvld1_q;
  assign o_rdat0 = rdat0_q;
  assign o_rdat1 = rdat1_q;
endmodule

// File: tb/tb_ram2p_arb.sv
// tb_ram2p_arb: directed self-checking bench for ram2p_arb with a write-first RAM model
module tb_ram2p_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic vld0 = 1'b0, vld1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, ram_addr;
  logic [15:0] dat0 = '0, dat1 = '0, rdat0, rdat1, ram_dat, ram_q;
  logic rdy0, rdy1, rvld0, rvld1, ram_we;
  logic [15:0] mem [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ram2p_arb dut (
    .clk(clk), .rst(rst),
    .i_vld0(vld0), .i_vld1(vld1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_dat0(dat0), .i_dat1(dat1),
    .o_rdy0(rdy0), .o_rdy1(rdy1), .o_rvld0(rvld0), .o_rvld1(rvld1),
    .o_rdat0(rdat0), .o_rdat1(rdat1),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_dat(ram_dat),
    .i_ram_dat(ram_q)
  );

  // RAM port A: write-first, one cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_dat;
    ram_q <= ram_we ? ram_dat : mem[ram_addr];
  end

  task automatic req(input logic v0, w0, input logic [7:0] a0, input logic [15:0] d0,
                     input logic v1, w1, input logic [7:0] a1, input logic [15:0] d1);
    @(posedge clk);
    #1;
    vld0 = v0; we0 = w0; addr0 = a0; dat0 = d0;
    vld1 = v1; we1 = w1; addr1 = a1; dat1 = d1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    req(1, 0, 8'd1, 0, 1, 0, 8'd2, 0);
    total++;
    if ({rdy0, rdy1, ram_we, rvld0, rvld1} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {rdy0, rdy1, ram_we, rvld0, rvld1});
    end
    total++;
    if (ram_addr !== 8'h0 || ram_dat !== 16'h0) begin
      bad++; $display("FAIL reset_cmd got=%h/%h want=00/0000", ram_addr, ram_dat);
    end
    total++;
    if (rdat0 !== 16'h0 || rdat1 !== 16'h0) begin
      bad++; $display("FAIL reset_rdat got=%h/%h want=0000/0000", rdat0, rdat1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
  endtask

  task automatic test_tie();
    req(1, 0, 8'd10, 0, 1, 0, 8'd20, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL tie_first got=%b want=10", {rdy0, rdy1}); end
    req(0, 0, 0, 0, 1, 0, 8'd20, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL tie_handoff got=%b want=01", {rdy0, rdy1}); end
    idle(1);
    req(1, 0, 8'd10, 0, 1, 0, 8'd20, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL tie_after1 got=%b want=10", {rdy0, rdy1}); end
    idle(1);
    req(1, 0, 8'd10, 0, 0, 0, 0, 0);
    idle(1);
    req(1, 0, 8'd10, 0, 1, 0, 8'd20, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL tie_after0 got=%b want=01", {rdy0, rdy1}); end
    idle(4);
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    logic e;
    for (int k = 0; k < 64; k++) begin
      req(1, 0, 8'd0, 0, 1, 0, 8'd0, 0);
      e = ((k / 4) % 2) == 1;
      total++;
      if ({rdy0, rdy1} !== {!e, e}) begin
        bad++; $display("FAIL rr_grant cyc=%0d got=%b want=%b", k, {rdy0, rdy1}, {!e, e});
      end
      n0 += int'(rdy0);
      n1 += int'(rdy1);
    end
    total++;
    if (n0 != 32 || n1 != 32) begin bad++; $display("FAIL rr_count got=%0d/%0d want=32/32", n0, n1); end
    idle(4);
  endtask

  task automatic test_single();
    logic ev;
    for (int k = 0; k < 516; k++) begin
      if (k < 256) req(1, 1, 8'(k), 16'(k), 0, 0, 0, 0);
      else if (k < 512) req(1, 0, 8'(k - 256), 0, 0, 0, 0, 0);
      else idle(1);
      if (k < 512) begin
        total++;
        if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL single_rdy cyc=%0d got=%b want=10", k, {rdy0, rdy1}); end
      end
      total++;
      if (k >= 1 && k <= 256) begin
        if (ram_we !== 1'b1 || ram_addr !== 8'(k - 1) || ram_dat !== 16'(k - 1)) begin
          bad++; $display("FAIL single_wr cyc=%0d got=%b/%h/%h want=1/%h/%h", k, ram_we, ram_addr, ram_dat, 8'(k - 1), 16'(k - 1));
        end
      end else if (ram_we !== 1'b0) begin
        bad++; $display("FAIL single_nowe cyc=%0d got=%b want=0", k, ram_we);
      end
      ev = k >= 259 && k <= 514;
      total++;
      if (rvld0 !== ev || rvld1 !== 1'b0) begin
        bad++; $display("FAIL single_rvld cyc=%0d got=%b%b want=%b0", k, rvld0, rvld1, ev);
      end
      if (ev) begin
        total++;
        if (rdat0 !== 16'(k - 259)) begin bad++; $display("FAIL single_rdat cyc=%0d got=%h want=%h", k, rdat0, 16'(k - 259)); end
      end
    end
    idle(3);
  endtask

  task automatic test_interleave();
    req(1, 0, 8'd5, 0, 0, 0, 0, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL il_rdy0 got=%b want=10", {rdy0, rdy1}); end
    req(0, 0, 0, 0, 1, 0, 8'd9, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL il_rdy1 got=%b want=01", {rdy0, rdy1}); end
    idle(1);
    total++;
    if ({rvld0, rvld1} !== 2'b00) begin bad++; $display("FAIL il_early got=%b want=00", {rvld0, rvld1}); end
    idle(1);
    total++;
    if ({rvld0, rvld1} !== 2'b10 || rdat0 !== 16'd5) begin
      bad++; $display("FAIL il_ret0 got=%b/%h want=10/0005", {rvld0, rvld1}, rdat0);
    end
    idle(1);
    total++;
    if ({rvld0, rvld1} !== 2'b01 || rdat1 !== 16'd9 || rdat0 !== 16'd5) begin
      bad++; $display("FAIL il_ret1 got=%b/%h/%h want=01/0009/0005", {rvld0, rvld1}, rdat1, rdat0);
    end
    idle(3);
  endtask

  task automatic test_hazard();
    req(0, 0, 0, 0, 1, 1, 8'd3, 16'hBEEF);
    total++;
    if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL hz_wr_rdy got=%b want=01", {rdy0, rdy1}); end
    req(1, 0, 8'd3, 0, 0, 0, 0, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b10 || ram_we !== 1'b1 || ram_addr !== 8'd3 || ram_dat !== 16'hBEEF) begin
      bad++; $display("FAIL hz_cmd got=%b/%b/%h/%h want=10/1/03/beef", {rdy0, rdy1}, ram_we, ram_addr, ram_dat);
    end
    idle(1);
    total++;
    if (ram_we !== 1'b0 || ram_addr !== 8'd3) begin bad++; $display("FAIL hz_rdcmd got=%b/%h want=0/03", ram_we, ram_addr); end
    idle(1);
    total++;
    if (ram_addr !== 8'd3) begin bad++; $display("FAIL hz_hold got=%h want=03", ram_addr); end
    idle(1);
    total++;
    if (rvld0 !== 1'b1 || rdat0 !== 16'hBEEF) begin bad++; $display("FAIL hz_data got=%b/%h want=1/beef", rvld0, rdat0); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    req(1, 0, 8'd5, 0, 0, 0, 0, 0);
    req(0, 0, 0, 0, 1, 0, 8'd9, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; vld0 = 1'b1; vld1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy0, rdy1} !== 2'b00) begin bad++; $display("FAIL rm_rdy got=%b want=00", {rdy0, rdy1}); end
    @(posedge clk);
    #1;
    rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    @(negedge clk);
    total++;
    if ({rvld0, rvld1, ram_we} !== 3'b0 || ram_addr !== 8'h0 || ram_dat !== 16'h0 || rdat0 !== 16'h0 || rdat1 !== 16'h0) begin
      bad++; $display("FAIL rm_outs got=%b/%h/%h/%h/%h want=000/00/0000/0000/0000", {rvld0, rvld1, ram_we}, ram_addr, ram_dat, rdat0, rdat1);
    end
    idle(1);
    total++;
    if ({rvld0, rvld1} !== 2'b00) begin bad++; $display("FAIL rm_late got=%b want=00", {rvld0, rvld1}); end
    idle(1);
    req(1, 1, 8'd5, 16'hDEAD, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; vld0 = 1'b0;
    @(negedge clk);
    total++;
    if (ram_we !== 1'b0) begin bad++; $display("FAIL rm_wecancel got=%b want=0", ram_we); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req(1, 0, 8'd5, 0, 1, 0, 8'd9, 0);
    total++;
    if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL rm_tie got=%b want=10", {rdy0, rdy1}); end
    idle(3);
    total++;
    if (rvld0 !== 1'b1 || rdat0 !== 16'd5) begin bad++; $display("FAIL rm_data got=%b/%h want=1/0005", rvld0, rdat0); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_round_robin();
    test_single();
    test_interleave();
    test_hazard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
